// File: rtl/decode_pkg.sv
// Shared types and constants for the Thumb-16 decoder: operand modes, ALU functions,
// branch condition codes and architectural register numbers.
package decode_pkg;

  typedef enum logic [1:0] {
    ModeNop    = 2'b00,
    ModeAluReg = 2'b01,
    ModeAluImm = 2'b10,
    ModeBranch = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOrr = 3'b011,
    AluEor = 3'b100,
    AluMov = 3'b101,
    AluMvn = 3'b110,
    AluCmp = 3'b111
  } alu_e;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;

  localparam logic [3:0] RegSp = 4'd13;
  localparam logic [3:0] RegPc = 4'd15;

endpackage

// File: rtl/decode_cond_check.sv
// Combinational ARM condition evaluation against APSR {N,Z,C,V}.
// Encodings 1110/1111 never pass, so they fall through to a NOP in the decoder.
module cond_check
  import decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] apsr,
  output logic       pass
);

  logic n, z, c, v;

  assign n = apsr[3];
  assign z = apsr[2];
  assign c = apsr[1];
  assign v = apsr[0];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      CondEq:  pass = z;
      CondNe:  pass = !z;
      CondCs:  pass = c;
      CondCc:  pass = !c;
      CondMi:  pass = n;
      CondPl:  pass = !n;
      CondVs:  pass = v;
      CondVc:  pass = !v;
      CondHi:  pass = c && !z;
      CondLs:  pass = !c || z;
      CondGe:  pass = (n == v);
      CondLt:  pass = (n != v);
      CondGt:  pass = !z && (n == v);
      CondLe:  pass = z || (n != v);
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// Registered Thumb-16 decoder: one instruction per cycle to register addresses, extended
// immediate, operand mode and ALU function. Unsupported or condition-failed encodings give a NOP.
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_ir,
  input  logic [3:0]  i_apsr,
  output logic [3:0]  o_addrrn_r,
  output logic [3:0]  o_addrrd_r,
  output logic [3:0]  o_addrrt_r,
  output logic [31:0] o_imm_r,
  output logic [1:0]  o_mode_r,
  output logic [2:0]  o_alusel_r
);

  logic        cond_pass;
  logic [3:0]  rn_d, rd_d, rt_d;
  logic [31:0] imm_d;
  mode_e       mode_d;
  alu_e        alusel_d;
  alu_e        dp_alu;
  logic        dp_ok;

  cond_check u_cond_check (
    .cond (i_ir[11:8]),
    .apsr (i_apsr),
    .pass (cond_pass)
  );

  // Data-processing opcode table; anything not listed is rejected as a NOP.
  always_comb begin
    dp_ok  = 1'b1;
    dp_alu = AluAdd;
    case (i_ir[9:6])
      4'b0000: dp_alu = AluAnd;
      4'b0001: dp_alu = AluEor;
      4'b1100: dp_alu = AluOrr;
      4'b1010: dp_alu = AluCmp;
      4'b1111: dp_alu = AluMvn;
      default: dp_ok  = 1'b0;
    endcase
  end

  always_comb begin
    rn_d     = 4'd0;
    rd_d     = 4'd0;
    rt_d     = 4'd0;
    imm_d    = 32'd0;
    mode_d   = ModeNop;
    alusel_d = AluAdd;
    casez (i_ir)
      16'b0001_10??_????_????: begin
        mode_d   = ModeAluReg;
        rt_d     = {1'b0, i_ir[8:6]};
        rn_d     = {1'b0, i_ir[5:3]};
        rd_d     = {1'b0, i_ir[2:0]};
        alusel_d = i_ir[9] ? AluSub : AluAdd;
      end
      16'b0001_11??_????_????: begin
        mode_d   = ModeAluImm;
        imm_d    = {29'd0, i_ir[8:6]};
        rn_d     = {1'b0, i_ir[5:3]};
        rd_d     = {1'b0, i_ir[2:0]};
        alusel_d = i_ir[9] ? AluSub : AluAdd;
      end
      16'b001?_????_????_????: begin
        mode_d = ModeAluImm;
        rn_d   = {1'b0, i_ir[10:8]};
        rd_d   = {1'b0, i_ir[10:8]};
        imm_d  = {24'd0, i_ir[7:0]};
        unique case (i_ir[12:11])
          2'b00:   alusel_d = AluMov;
          2'b01:   alusel_d = AluCmp;
          2'b10:   alusel_d = AluAdd;
          default: alusel_d = AluSub;
        endcase
      end
      16'b0100_00??_????_????: begin
        if (dp_ok) begin
          mode_d   = ModeAluReg;
          rt_d     = {1'b0, i_ir[5:3]};
          rn_d     = {1'b0, i_ir[2:0]};
          rd_d     = {1'b0, i_ir[2:0]};
          alusel_d = dp_alu;
        end
      end
      16'b1011_0000_????_????: begin
        mode_d   = ModeAluImm;
        rn_d     = RegSp;
        rd_d     = RegSp;
        imm_d    = {23'd0, i_ir[6:0], 2'b00};
        alusel_d = i_ir[7] ? AluSub : AluAdd;
      end
      16'b1101_????_????_????: begin
        if (cond_pass) begin
          mode_d = ModeBranch;
          rn_d   = RegPc;
          rd_d   = RegPc;
          imm_d  = {{23{i_ir[7]}}, i_ir[7:0], 1'b0};
        end
      end
      16'b1110_0???_????_????: begin
        mode_d = ModeBranch;
        rn_d   = RegPc;
        rd_d   = RegPc;
        imm_d  = {{20{i_ir[10]}}, i_ir[10:0], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_addrrn_r <= 4'd0;
      o_addrrd_r <= 4'd0;
      o_addrrt_r <= 4'd0;
      o_imm_r    <= 32'd0;
      o_mode_r   <= ModeNop;
      o_alusel_r <= AluAdd;
    end else begin
      o_addrrn_r <= rn_d;
      o_addrrd_r <= rd_d;
      o_addrrt_r <= rt_d;
      o_imm_r    <= imm_d;
      o_mode_r   <= mode_d;
      o_alusel_r <= alusel_d;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed, table-driven bench for the Thumb-16 decoder with reset sequences around the table.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_ir;
  logic [3:0]  i_apsr;
  logic [3:0]  o_addrrn_r, o_addrrd_r, o_addrrt_r;
  logic [31:0] o_imm_r;
  logic [1:0]  o_mode_r;
  logic [2:0]  o_alusel_r;

  int checks = 0;
  int errors = 0;

  decode dut (
    .clk        (clk),
    .rst        (rst),
    .i_ir       (i_ir),
    .i_apsr     (i_apsr),
    .o_addrrn_r (o_addrrn_r),
    .o_addrrd_r (o_addrrd_r),
    .o_addrrt_r (o_addrrt_r),
    .o_imm_r    (o_imm_r),
    .o_mode_r   (o_mode_r),
    .o_alusel_r (o_alusel_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [3:0]  apsr;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rt;
    logic [31:0] imm;
    logic [1:0]  mode;
    logic [2:0]  alu;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [15:0] ir, input logic [3:0] apsr,
                     input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rt,
                     input logic [31:0] imm, input logic [1:0] mode, input logic [2:0] alu);
    vec_t v;
    v.name = name; v.ir = ir; v.apsr = apsr; v.rn = rn; v.rd = rd; v.rt = rt;
    v.imm = imm; v.mode = mode; v.alu = alu;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic r, input logic [15:0] ir, input logic [3:0] apsr);
    @(negedge clk);
    rst = r; i_ir = ir; i_apsr = apsr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] rn, input logic [3:0] rd,
                       input logic [3:0] rt, input logic [31:0] imm, input logic [1:0] mode,
                       input logic [2:0] alu);
    logic [48:0] act, exp;
    act = {o_addrrn_r, o_addrrd_r, o_addrrt_r, o_imm_r, o_mode_r, o_alusel_r};
    exp = {rn, rd, rt, imm, mode, alu};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rn=%0d rd=%0d rt=%0d imm=%h mode=%b alu=%b, want rn=%0d rd=%0d rt=%0d imm=%h mode=%b alu=%b",
               name, o_addrrn_r, o_addrrd_r, o_addrrt_r, o_imm_r, o_mode_r, o_alusel_r,
               rn, rd, rt, imm, mode, alu);
    end
  endtask

  task automatic check_nop(input string name);
    check(name, 4'd0, 4'd0, 4'd0, 32'd0, 2'b00, 3'b000);
  endtask

  initial begin
    rst = 1'b1; i_ir = 16'h0000; i_apsr = 4'h0;

    //   name           ir        apsr   rn  rd  rt  imm            mode   alu
    add("add_imm3",   16'h1C53, 4'h0,  2,  3,  0, 32'h00000001, 2'b10, 3'b000);
    add("sub_sp",     16'hB081, 4'h0, 13, 13,  0, 32'h00000004, 2'b10, 3'b001);
    add("add_sp_max", 16'hB07F, 4'h0, 13, 13,  0, 32'h000001FC, 2'b10, 3'b000);
    add("ands",       16'h400C, 4'h0,  4,  4,  1, 32'h00000000, 2'b01, 3'b010);
    add("dp_opc1000", 16'h4200, 4'h0,  0,  0,  0, 32'h00000000, 2'b00, 3'b000);
    add("eors",       16'h4048, 4'h0,  0,  0,  1, 32'h00000000, 2'b01, 3'b100);
    add("orrs",       16'h430A, 4'h0,  2,  2,  1, 32'h00000000, 2'b01, 3'b011);
    add("cmp_reg",    16'h429C, 4'h0,  4,  4,  3, 32'h00000000, 2'b01, 3'b111);
    add("mvns",       16'h43EE, 4'h0,  6,  6,  5, 32'h00000000, 2'b01, 3'b110);
    add("add_reg",    16'h1853, 4'h0,  2,  3,  1, 32'h00000000, 2'b01, 3'b000);
    add("sub_reg",    16'h1A53, 4'h0,  2,  3,  1, 32'h00000000, 2'b01, 3'b001);
    add("beq_taken",  16'hD0FE, 4'h4, 15, 15,  0, 32'hFFFFFFFC, 2'b11, 3'b000);
    add("beq_not",    16'hD0FE, 4'h0,  0,  0,  0, 32'h00000000, 2'b00, 3'b000);
    add("bne_taken",  16'hD104, 4'h0, 15, 15,  0, 32'h00000008, 2'b11, 3'b000);
    add("bhi_taken",  16'hD810, 4'h2, 15, 15,  0, 32'h00000020, 2'b11, 3'b000);
    add("bge_taken",  16'hDA02, 4'h9, 15, 15,  0, 32'h00000004, 2'b11, 3'b000);
    add("blt_not",    16'hDB02, 4'h9,  0,  0,  0, 32'h00000000, 2'b00, 3'b000);
    add("bgt_not",    16'hDC02, 4'h4,  0,  0,  0, 32'h00000000, 2'b00, 3'b000);
    add("ble_taken",  16'hDD02, 4'h1, 15, 15,  0, 32'h00000004, 2'b11, 3'b000);
    add("cond_1110",  16'hDE00, 4'hF,  0,  0,  0, 32'h00000000, 2'b00, 3'b000);
    add("b_minus2",   16'hE7FF, 4'h0, 15, 15,  0, 32'hFFFFFFFE, 2'b11, 3'b000);
    add("b_most_neg", 16'hE400, 4'h0, 15, 15,  0, 32'hFFFFF800, 2'b11, 3'b000);
    add("mov_imm8",   16'h2280, 4'h0,  2,  2,  0, 32'h00000080, 2'b10, 3'b101);
    // 0x2A80 has op=01, i.e. CMP r2,#0x80
    add("cmp_imm8",   16'h2A80, 4'h0,  2,  2,  0, 32'h00000080, 2'b10, 3'b111);
    add("add_imm8",   16'h3105, 4'h0,  1,  1,  0, 32'h00000005, 2'b10, 3'b000);
    add("sub_imm8",   16'h3905, 4'h0,  1,  1,  0, 32'h00000005, 2'b10, 3'b001);
    add("prefix_1d",  16'hE800, 4'h0,  0,  0,  0, 32'h00000000, 2'b00, 3'b000);
    add("prefix_1f",  16'hF000, 4'h0,  0,  0,  0, 32'h00000000, 2'b00, 3'b000);

    // Reset held two cycles with a decodable instruction present: outputs must stay zero.
    step(1'b1, 16'hE7FF, 4'h0);
    check_nop("reset_cycle1");
    step(1'b1, 16'hE7FF, 4'h0);
    check_nop("reset_cycle2");

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].ir, vecs[i].apsr);
      check(vecs[i].name, vecs[i].rn, vecs[i].rd, vecs[i].rt, vecs[i].imm, vecs[i].mode,
            vecs[i].alu);
    end

    // Back-to-back stream with a one-cycle reset in the middle.
    step(1'b0, 16'h1C53, 4'h0);
    check("stream_pre", 4'd2, 4'd3, 4'd0, 32'd1, 2'b10, 3'b000);
    step(1'b1, 16'h400C, 4'h0);
    check_nop("stream_rst");
    step(1'b0, 16'hB081, 4'h0);
    check("stream_post", 4'd13, 4'd13, 4'd0, 32'd4, 2'b10, 3'b001);
    step(1'b0, 16'hD0FE, 4'h4);
    check("stream_beq", 4'd15, 4'd15, 4'd0, 32'hFFFFFFFC, 2'b11, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
